// File: rtl/display_pkg.sv
// display_pkg: constants and small helpers shared by the display scanner.
// A dark digit is signalled to the segment decoder as DARK_CODE.
package display_pkg;
   localparam logic [3:0] DARK_CODE = 4'hF;
   localparam int DEF_NUM_DIGITS = 8;
   localparam int DIGIT_W = 4;
   function automatic int field_lsb(input int i);
      return i * DIGIT_W;
   endfunction
   function automatic int cnt_w(input int div);
      return div > 1 ? $clog2(div) : 1;
   endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running modulo-DIV counter; tick is high while the count sits at DIV-1.
module tick_gen
   import display_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [cnt_w(DIV)-1:0]  count,
   output logic                   tick
);
   localparam int W = cnt_w(DIV);
   assign tick = count == W'(DIV - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/digit_scan.sv
// digit_scan: time-multiplexed 7-segment digit scanner with per-frame snapshot,
// blank/blink/leading-zero darkening and an anti-ghost guard at each slot start.
module digit_scan
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 500,
   parameter int BLINK_DIV    = 25000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lz_en,
   output logic [3:0]              num,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);
   localparam int CW = cnt_w(REFRESH_DIV);
   localparam int IW = cnt_w(NUM_DIGITS);
   localparam logic [CW-1:0] GUARD = CW'(GUARD_CYCLES);
   logic [CW-1:0] cnt;
   logic [cnt_w(BLINK_DIV)-1:0] blink_cnt_unused;
   logic tick, blink_tick, blink_phase, snap_lz, loaded, wrap, above;
   logic [IW-1:0] idx;
   logic [4*NUM_DIGITS-1:0] snap;
   logic [NUM_DIGITS-1:0] snap_blank, snap_blink, sup, dark, sel;
   logic [3:0] cur;
   tick_gen #(.DIV(REFRESH_DIV)) u_slot (.clk, .rst, .count(cnt), .tick);
   tick_gen #(.DIV(BLINK_DIV)) u_blink (.clk, .rst, .count(blink_cnt_unused), .tick(blink_tick));
   assign wrap = tick && idx == IW'(NUM_DIGITS - 1);
   // Scan from the top digit down; a zero is suppressed only while everything above it is zero or blank.
   always_comb begin
      above = 1'b1;
      sup = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         sup[i] = snap_lz && above && snap[field_lsb(i) +: 4] == 4'h0;
         above = above && (snap[field_lsb(i) +: 4] == 4'h0 || snap_blank[i]);
      end
      dark = snap_blank | (snap_blink & {NUM_DIGITS{blink_phase}}) | sup;
      cur = DARK_CODE;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         sel[i] = idx == IW'(i);
         cur = sel[i] ? snap[field_lsb(i) +: 4] : cur;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         idx         <= '0;
         snap        <= '1;
         snap_blank  <= '0;
         snap_blink  <= '0;
         snap_lz     <= 1'b0;
         loaded      <= 1'b0;
         blink_phase <= 1'b0;
         frame_start <= 1'b0;
         num         <= DARK_CODE;
         an          <= '1;
      end else begin
         idx         <= wrap ? '0 : idx + IW'(tick);
         snap        <= wrap ? digits : snap;
         snap_blank  <= wrap ? blank_mask : snap_blank;
         snap_blink  <= wrap ? blink_mask : snap_blink;
         snap_lz     <= wrap ? lz_en : snap_lz;
         loaded      <= loaded | wrap;
         blink_phase <= blink_phase ^ blink_tick;
         frame_start <= wrap;
         num         <= (!en || |(dark & sel)) ? DARK_CODE : cur;
         an          <= (!en || !loaded || cnt < GUARD) ? '1 : ~sel;
      end
endmodule
